// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared types and helpers for the round-robin ALU arbiter:
//   arb_state_t : arbiter FSM states (IDLE, EXEC, RESP)
//   ALU_*       : alucontrol encodings understood by the shared ALU
//   rr_pick     : round-robin selection over up to 8 request lines
// No ports (package).
// -----------------------------------------------------------------------------
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Result of a round-robin search: found=0 means no line was requesting.
  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_grant_t;

  // First set bit of valid, scanning ptr, ptr+1, ... modulo n (n in 1..8,
  // ptr < n). Bits at or above n are never considered.
  function automatic rr_grant_t rr_pick(input logic [7:0] valid,
                                        input logic [2:0] ptr,
                                        input logic [3:0] n);
    rr_grant_t  g;
    logic [3:0] cand;
    g.found = 1'b0;
    g.idx   = 3'b000;
    for (int k = 0; k < 8; k++) begin
      // ptr < n and k < n, so a single subtraction performs the modulo.
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= n) begin
        cand = cand - n;
      end else begin
        cand = cand;
      end
      if ((4'(k) < n) && !g.found && valid[cand[2:0]]) begin
        g.found = 1'b1;
        g.idx   = cand[2:0];
      end else begin
        g = g;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the per-requester request/response channels of the ALU arbiter.
//   req_valid/req_ready : request handshake, one bit per requester
//   req_a/req_b/req_op  : operands and alucontrol, one lane per requester
//   rsp_valid/rsp_ready : response handshake, one bit per requester
//   rsp_result/rsp_zero : shared response bus, qualified by rsp_valid
//   busy                : arbiter is not idle
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface alu_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0][XLEN-1:0] req_a;
  logic [NUM_REQ-1:0][XLEN-1:0] req_b;
  logic [NUM_REQ-1:0][2:0]      req_op;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [NUM_REQ-1:0]           rsp_ready;
  logic [XLEN-1:0]              rsp_result;
  logic                         rsp_zero;
  logic                         busy;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, busy
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// -----------------------------------------------------------------------------
// alu_arbiter_alu
// Combinational ALU shared by all requesters of the arbiter.
//   a_i, b_i      : XLEN-bit operands
//   alucontrol_i  : operation select; bit 2 has no effect
//   result_o      : XLEN-bit result, wraps modulo 2^XLEN
//   zero_o        : 1 when result_o is all zeros
// -----------------------------------------------------------------------------
module alu_arbiter_alu
  import alu_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [2:0]      alucontrol_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  logic [2:0] op_s;

  // Bit 2 of alucontrol is masked off so 1xx aliases onto 0xx.
  assign op_s = alucontrol_i & 3'b011;

  // Operation decode.
  always_comb begin
    result_o = {XLEN{1'b0}};
    case (op_s)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i + ~b_i + XLEN'(1'b1);
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      default: result_o = {XLEN{1'b0}};
    endcase
  end

  assign zero_o = (result_o == {XLEN{1'b0}});

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between NUM_REQ requesters using round-robin arbitration.
// A granted request's operands are latched, the ALU result is registered one
// cycle later, and the response is held until the owning requester takes it.
//   clk   : system clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : alu_arbiter_if slave modport (request/response channels, busy)
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_REQ = 2,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  arb_state_t       state_q,  state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   tag_q,    tag_d;
  logic [XLEN-1:0]  a_q,      a_d;
  logic [XLEN-1:0]  b_q,      b_d;
  logic [2:0]       op_q,     op_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             zero_q,   zero_d;

  rr_grant_t        grant_s;
  logic [IDW-1:0]   gnt_idx_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic [NUM_REQ-1:0] rsp_valid_s;
  logic [XLEN-1:0]  alu_result_s;
  logic             alu_zero_s;

  // The search only matters in IDLE; elsewhere its result is ignored.
  assign grant_s   = rr_pick(8'(bus.req_valid), 3'(rr_ptr_q), 4'(NUM_REQ));
  assign gnt_idx_s = IDW'(grant_s.idx);

  alu_arbiter_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .a_i          (a_q),
    .b_i          (b_q),
    .alucontrol_i (op_q),
    .result_o     (alu_result_s),
    .zero_o       (alu_zero_s)
  );

  // Next-state, latch enables and request-side handshake.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    tag_d       = tag_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    result_d    = result_q;
    zero_d      = zero_q;
    req_ready_s = {NUM_REQ{1'b0}};
    case (state_q)
      IDLE: begin
        if (grant_s.found) begin
          req_ready_s[gnt_idx_s] = 1'b1;
          a_d     = bus.req_a[gnt_idx_s];
          b_d     = bus.req_b[gnt_idx_s];
          op_d    = bus.req_op[gnt_idx_s];
          tag_d   = gnt_idx_s;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        result_d = alu_result_s;
        zero_d   = alu_zero_s;
        state_d  = RESP;
      end
      RESP: begin
        // Only the owner's rsp_ready completes the transfer; the pointer
        // moves past the owner so it yields to the others next time.
        if (bus.rsp_ready[tag_q]) begin
          if (tag_q == IDW'(NUM_REQ - 1)) begin
            rr_ptr_d = {IDW{1'b0}};
          end else begin
            rr_ptr_d = tag_q + IDW'(1'b1);
          end
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= {IDW{1'b0}};
      tag_q    <= {IDW{1'b0}};
      a_q      <= {XLEN{1'b0}};
      b_q      <= {XLEN{1'b0}};
      op_q     <= 3'b000;
      result_q <= {XLEN{1'b0}};
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      tag_q    <= tag_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  // Response valid decodes straight from registered state and tag.
  always_comb begin
    rsp_valid_s = {NUM_REQ{1'b0}};
    if (state_q == RESP) begin
      rsp_valid_s[tag_q] = 1'b1;
    end else begin
      rsp_valid_s = {NUM_REQ{1'b0}};
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.rsp_valid  = rsp_valid_s;
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter (XLEN=32, NUM_REQ=2): a vector table of
// single operations, hand-written multi-cycle sequences (fair alternation,
// backpressure, reset abort) and a randomized run against a transaction-level
// reference model.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int XL = 32;
  localparam int N  = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_arbiter_if #(.XLEN(XL), .NUM_REQ(N)) bus ();

  alu_arbiter #(.XLEN(XL), .NUM_REQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        z;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = '0;
  endtask

  // Tasks start and end in the drive phase: just after a rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_result", bus.rsp_result, 0);
    chk("rst_zero", bus.rsp_zero, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && bus.busy; i++) begin
      @(posedge clk); #1;
    end
    chk("idle_timeout", bus.busy, 0);
  endtask

  task automatic single_op(input vec_t v, input string nm);
    logic [N-1:0] oh;
    oh = N'(1) << v.r;
    bus.req_valid     = oh;
    bus.req_a[v.r]    = v.a;
    bus.req_b[v.r]    = v.b;
    bus.req_op[v.r]   = v.op;
    @(negedge clk);
    chk({nm, "_ready"}, bus.req_ready, oh);
    @(posedge clk); #1 bus.req_valid = '0;
    @(negedge clk);
    chk({nm, "_exec_valid"}, bus.rsp_valid, 0);
    chk({nm, "_exec_busy"}, bus.busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_rsp_valid"}, bus.rsp_valid, oh);
    chk({nm, "_result"}, bus.rsp_result, v.res);
    chk({nm, "_zero"}, bus.rsp_zero, v.z);
    @(posedge clk); #1 bus.rsp_ready = oh;
    @(negedge clk);
    chk({nm, "_held"}, {bus.rsp_valid, bus.rsp_result}, {oh, v.res});
    @(posedge clk); #1 bus.rsp_ready = '0;
    @(negedge clk);
    chk({nm, "_done"}, {bus.busy, bus.rsp_valid}, 0);
    @(posedge clk); #1;
  endtask

  // Randomized run against a transaction-level model.
  task automatic random_run(input int cycles);
    logic        vld [N];
    logic [31:0] va  [N];
    logic [31:0] vb  [N];
    logic [2:0]  vop [N];
    int          ptr, cyc, pend_r, pend_cyc, g;
    logic        pend;
    logic [31:0] pend_res;
    logic [N-1:0] exp_ready, exp_valid;
    ptr = 0; cyc = 0; pend = 1'b0; pend_r = 0; pend_cyc = 0; pend_res = '0;
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0; va[i] = '0; vb[i] = '0; vop[i] = '0;
    end
    for (int t = 0; t < cycles; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && $urandom_range(0, 2) == 0) begin
          vld[i] = 1'b1;
          va[i]  = $urandom;
          vb[i]  = ($urandom_range(0, 3) == 0) ? va[i] : $urandom;
          vop[i] = 3'($urandom_range(0, 7));
        end else if (vld[i] && $urandom_range(0, 15) == 0) begin
          vld[i] = 1'b0;
        end
        bus.req_valid[i] = vld[i];
        bus.req_a[i]     = va[i];
        bus.req_b[i]     = vb[i];
        bus.req_op[i]    = vop[i];
      end
      bus.rsp_ready = N'($urandom_range(0, 3));
      @(negedge clk);
      cyc++;
      exp_ready = '0;
      g = -1;
      if (!pend) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && vld[(ptr + k) % N]) g = (ptr + k) % N;
        end
        if (g >= 0) exp_ready = N'(1) << g;
      end
      chk("rnd_ready", bus.req_ready, exp_ready);
      exp_valid = (pend && cyc >= pend_cyc + 2) ? (N'(1) << pend_r) : '0;
      chk("rnd_rsp_valid", bus.rsp_valid, exp_valid);
      if (exp_valid != 0) begin
        chk("rnd_result", bus.rsp_result, pend_res);
        chk("rnd_zero", bus.rsp_zero, pend_res == 0);
        if (bus.rsp_ready[pend_r]) begin
          pend = 1'b0;
          ptr  = (pend_r + 1) % N;
        end
      end
      if (g >= 0) begin
        pend     = 1'b1;
        pend_r   = g;
        pend_res = ref_alu(va[g], vb[g], vop[g]);
        pend_cyc = cyc;
        vld[g]   = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    wait_idle();
    bus.rsp_ready = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int grants;
    int exp_g;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clear_inputs();

    vecs[0] = '{0, 32'd5,          32'd3,        3'b000, 32'd8,          1'b0};
    vecs[1] = '{1, 32'd7,          32'd7,        3'b001, 32'd0,          1'b1};
    vecs[2] = '{1, 32'd3,          32'd5,        3'b001, 32'hFFFF_FFFE,  1'b0};
    vecs[3] = '{0, 32'h0000_00F0,  32'h0000_003C, 3'b110, 32'h0000_0030, 1'b0};
    vecs[4] = '{0, 32'h0000_00F0,  32'h0000_003C, 3'b011, 32'h0000_00FC, 1'b0};
    vecs[5] = '{1, 32'hFFFF_FFFF,  32'd1,        3'b000, 32'd0,          1'b1};
    vecs[6] = '{0, 32'h0000_AAAA,  32'h0000_5555, 3'b010, 32'd0,         1'b1};
    vecs[7] = '{1, 32'd0,          32'd1,        3'b101, 32'hFFFF_FFFF,  1'b0};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      single_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Both requesters valid continuously: grants must alternate 0,1,0,1.
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_a[0] = 32'd1;  bus.req_b[0] = 32'd1; bus.req_op[0] = 3'b000;
    bus.req_a[1] = 32'd10; bus.req_b[1] = 32'd3; bus.req_op[1] = 3'b001;
    bus.rsp_ready = 2'b11;
    grants = 0;
    exp_g  = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.req_ready != 0) begin
        chk("alt_grant", bus.req_ready, N'(1) << exp_g);
        exp_g = 1 - exp_g;
        grants++;
      end
      if (bus.rsp_valid != 0) begin
        chk("alt_result", bus.rsp_result, bus.rsp_valid[0] ? 32'd2 : 32'd7);
      end
      @(posedge clk); #1;
    end
    chk("alt_count", grants, 4);
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    wait_idle();

    // Backpressure: response held, other requester blocked, foreign ready ignored.
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_a[0] = 32'd9; bus.req_b[0] = 32'd1; bus.req_op[0] = 3'b001;
    @(negedge clk);
    chk("bp_grant0", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    bus.req_a[1] = 32'd4; bus.req_b[1] = 32'd4; bus.req_op[1] = 3'b010;
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    chk("bp_exec_ready", bus.req_ready, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_valid", bus.rsp_valid, 2'b01);
      chk("bp_result", bus.rsp_result, 32'd8);
      chk("bp_zero", bus.rsp_zero, 0);
      chk("bp_ready", bus.req_ready, 0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    chk("bp_last_valid", bus.rsp_valid, 2'b01);
    @(posedge clk); #1 bus.rsp_ready = '0;
    @(negedge clk);
    chk("bp_grant1", bus.req_ready, 2'b10);
    @(posedge clk); #1 bus.req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_rsp1", {bus.rsp_valid, bus.rsp_result, bus.rsp_zero}, {2'b10, 32'd4, 1'b0});
    @(posedge clk); #1 bus.rsp_ready = 2'b10;
    @(posedge clk); #1 bus.rsp_ready = '0;
    wait_idle();

    // Reset during EXEC: op discarded, pointer back to 0, aborted requester re-granted.
    single_op(vecs[0], "pre_abort");
    bus.req_valid = 2'b10;
    bus.req_a[1] = 32'd6; bus.req_b[1] = 32'd1; bus.req_op[1] = 3'b000;
    @(negedge clk);
    chk("ab_grant1", bus.req_ready, 2'b10);
    @(posedge clk); #1;
    bus.req_valid = 2'b11;
    bus.req_a[0] = 32'd2; bus.req_b[0] = 32'd2; bus.req_op[0] = 3'b011;
    rst_n = 1'b0;
    @(negedge clk);
    chk("ab_exec_busy", bus.busy, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ab_busy", bus.busy, 0);
    chk("ab_rsp_valid", bus.rsp_valid, 0);
    chk("ab_result", bus.rsp_result, 0);
    chk("ab_ptr_zero", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    bus.rsp_ready = 2'b11;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ab_rsp0", {bus.rsp_valid, bus.rsp_result}, {2'b01, 32'd2});
    @(posedge clk); #1;
    @(negedge clk);
    chk("ab_regrant1", bus.req_ready, 2'b10);
    @(posedge clk); #1 bus.req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ab_rsp1", {bus.rsp_valid, bus.rsp_result}, {2'b10, 32'd7});
    @(posedge clk); #1 bus.rsp_ready = '0;
    wait_idle();

    do_reset();
    random_run(600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
